// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel coordinates, active flag and sync pulses for a VGA-style display.
// HSYNC/VSYNC/DE are delayed PIPE_DLY enabled cycles to line up with a registered colour stage.
module vga_sync_gen #(
  parameter int P_WIDTH  = 11,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 1
) (
  input  logic               VGA_CLK,
  input  logic               RST_N,
  input  logic               EN,
  output logic [P_WIDTH-1:0] X,
  output logic [P_WIDTH-1:0] Y,
  output logic               valid,
  output logic               FRAME_START,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic               DE
);

  localparam int LP_H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int LP_V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  // Window bounds are inclusive so no constant ever needs to hold H_TOTAL itself.
  localparam logic [P_WIDTH-1:0] LP_H_LAST     = P_WIDTH'(LP_H_TOTAL - 1);
  localparam logic [P_WIDTH-1:0] LP_V_LAST     = P_WIDTH'(LP_V_TOTAL - 1);
  localparam logic [P_WIDTH-1:0] LP_H_ACT      = P_WIDTH'(H_ACT);
  localparam logic [P_WIDTH-1:0] LP_V_ACT      = P_WIDTH'(V_ACT);
  localparam logic [P_WIDTH-1:0] LP_HS_FIRST   = P_WIDTH'(H_ACT + H_FP);
  localparam logic [P_WIDTH-1:0] LP_HS_LAST    = P_WIDTH'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [P_WIDTH-1:0] LP_VS_FIRST   = P_WIDTH'(V_ACT + V_FP);
  localparam logic [P_WIDTH-1:0] LP_VS_LAST    = P_WIDTH'(V_ACT + V_FP + V_SYNC - 1);

  logic [P_WIDTH-1:0] r_h_cnt;
  logic [P_WIDTH-1:0] r_v_cnt;
  logic [P_WIDTH-1:0] r_x;
  logic [P_WIDTH-1:0] r_y;
  logic               r_valid;
  logic               r_fs;
  logic               r_hs;
  logic               r_vs;

  logic w_h_wrap;
  logic w_v_wrap;
  logic w_active;
  logic w_hs_win;
  logic w_vs_win;

  assign w_h_wrap = (r_h_cnt == LP_H_LAST);
  assign w_v_wrap = (r_v_cnt == LP_V_LAST);
  assign w_active = (r_h_cnt < LP_H_ACT) && (r_v_cnt < LP_V_ACT);
  assign w_hs_win = (r_h_cnt >= LP_HS_FIRST) && (r_h_cnt <= LP_HS_LAST);
  assign w_vs_win = (r_v_cnt >= LP_VS_FIRST) && (r_v_cnt <= LP_VS_LAST);

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_fs    <= 1'b0;
      r_hs    <= ~HS_POL;
      r_vs    <= ~VS_POL;
    end else if (EN) begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + P_WIDTH'(1);
      if (w_h_wrap) begin
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + P_WIDTH'(1);
      end
      // Outputs decode the count before it advances, so the first edge out of reset shows (0,0).
      r_valid <= w_active;
      r_x     <= w_active ? r_h_cnt : '0;
      r_y     <= w_active ? r_v_cnt : '0;
      r_fs    <= (r_h_cnt == '0) && (r_v_cnt == '0);
      r_hs    <= w_hs_win ? HS_POL : ~HS_POL;
      r_vs    <= w_vs_win ? VS_POL : ~VS_POL;
    end
  end

  assign X           = r_x;
  assign Y           = r_y;
  assign valid       = r_valid;
  assign FRAME_START = r_fs;

  generate
    if (PIPE_DLY == 0) begin : g_no_dly
      assign HSYNC = r_hs;
      assign VSYNC = r_vs;
      assign DE    = r_valid;
    end else begin : g_dly
      // Each stage holds {hs, vs, valid}; reset loads deasserted levels so no stale sync survives.
      logic [2:0] r_dly [PIPE_DLY];

      always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
          for (int i = 0; i < PIPE_DLY; i++) begin
            r_dly[i] <= {~HS_POL, ~VS_POL, 1'b0};
          end
        end else if (EN) begin
          r_dly[0] <= {r_hs, r_vs, r_valid};
          for (int i = 1; i < PIPE_DLY; i++) begin
            r_dly[i] <= r_dly[i-1];
          end
        end
      end

      assign {HSYNC, VSYNC, DE} = r_dly[PIPE_DLY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default 640x480 builds at PIPE_DLY 0/1/3 plus a tiny raster
// instance small enough to run whole frames.
module tb_vga_sync_gen;

  logic        clk;
  logic        rst_n;
  logic        en;

  logic [10:0] x1, y1, x0, y0, x3, y3;
  logic        v1, fs1, hs1, vs1, de1;
  logic        v0, fs0, hs0, vs0, de0;
  logic        v3, fs3, hs3, vs3, de3;
  logic [3:0]  xs, ys;
  logic        vals, fss, hss, vss, des;

  int n_tests, n_fail;

  int n_val, x_err, y_err, var_mis, adv_err;
  int hs0_first, hs0_cnt, hs1_first, hs1_cnt, hs3_first;
  int de0_mis, de1_fall, de3_rise, de3_fall;
  int hold_err, en_val_clk, en_hs_clk, found, stale;
  int fs_cnt, fs_first, fs_second, vs_cnt, vs_first, ymax, xmax, de_mis, hs_s_cnt, hs_s_first;
  logic [10:0] px;
  logic        pv, phs, pvals;

  vga_sync_gen dut1 (
    .VGA_CLK(clk), .RST_N(rst_n), .EN(en), .X(x1), .Y(y1), .valid(v1),
    .FRAME_START(fs1), .HSYNC(hs1), .VSYNC(vs1), .DE(de1)
  );

  vga_sync_gen #(.PIPE_DLY(0)) dut0 (
    .VGA_CLK(clk), .RST_N(rst_n), .EN(en), .X(x0), .Y(y0), .valid(v0),
    .FRAME_START(fs0), .HSYNC(hs0), .VSYNC(vs0), .DE(de0)
  );

  vga_sync_gen #(.PIPE_DLY(3)) dut3 (
    .VGA_CLK(clk), .RST_N(rst_n), .EN(en), .X(x3), .Y(y3), .valid(v3),
    .FRAME_START(fs3), .HSYNC(hs3), .VSYNC(vs3), .DE(de3)
  );

  // 16 x 10 raster, 4-bit counters (H_TOTAL = 2^P_WIDTH), active-high HSYNC.
  vga_sync_gen #(
    .P_WIDTH(4), .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACT(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .PIPE_DLY(1)
  ) dut_s (
    .VGA_CLK(clk), .RST_N(rst_n), .EN(en), .X(xs), .Y(ys), .valid(vals),
    .FRAME_START(fss), .HSYNC(hss), .VSYNC(vss), .DE(des)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    en      = 1'b1;

    repeat (3) tick();
    check("rst_x",     32'(x1),  0);
    check("rst_y",     32'(y1),  0);
    check("rst_valid", 32'(v1),  0);
    check("rst_fs",    32'(fs1), 0);
    check("rst_de",    32'(de1), 0);
    check("rst_de3",   32'(de3), 0);
    check("rst_hs",    32'(hs1), 1);
    check("rst_vs",    32'(vs1), 1);
    check("rst_hs_s",  32'(hss), 0);
    check("rst_vs_s",  32'(vss), 1);

    rst_n = 1'b1;

    // One full line from reset exit.
    n_val = 0; x_err = 0; y_err = 0; var_mis = 0;
    hs0_first = 0; hs0_cnt = 0; hs1_first = 0; hs1_cnt = 0; hs3_first = 0;
    de0_mis = 0; de1_fall = 0; de3_rise = 0; de3_fall = 0;
    for (int k = 1; k <= 800; k++) begin
      tick();
      if (k == 1) begin
        check("first_valid", 32'(v1),  1);
        check("first_fs",    32'(fs1), 1);
        check("first_x",     32'(x1),  0);
        check("first_y",     32'(y1),  0);
        check("first_de",    32'(de1), 0);
      end
      if (k == 2) begin
        check("second_x",  32'(x1),  1);
        check("second_fs", 32'(fs1), 0);
        check("second_de", 32'(de1), 1);
      end
      if (v1) begin
        n_val++;
        if (int'(x1) != k - 1) x_err++;
      end else if (int'(x1) != 0) begin
        x_err++;
      end
      if (int'(y1) != 0) y_err++;
      if (x0 != x1 || x3 != x1 || y0 != y1 || y3 != y1 || v0 != v1 || v3 != v1 ||
          fs0 != fs1 || fs3 != fs1 || vs0 != vs1 || vs3 != vs1)
        var_mis++;
      if (!hs0) begin
        hs0_cnt++;
        if (hs0_first == 0) hs0_first = k;
      end
      if (!hs1) begin
        hs1_cnt++;
        if (hs1_first == 0) hs1_first = k;
      end
      if (!hs3 && hs3_first == 0) hs3_first = k;
      if (de0 != v0) de0_mis++;
      if (k > 2 && !de1 && de1_fall == 0) de1_fall = k;
      if (de3 && de3_rise == 0) de3_rise = k;
      if (k > 4 && !de3 && de3_fall == 0) de3_fall = k;
    end
    check("line_valid_cnt", n_val,     640);
    check("line_x_seq",     x_err,     0);
    check("line_y",         y_err,     0);
    check("line_build_mis", var_mis,   0);
    check("hs0_first",      hs0_first, 657);
    check("hs0_width",      hs0_cnt,   96);
    check("hs1_first",      hs1_first, 658);
    check("hs1_width",      hs1_cnt,   96);
    check("hs3_first",      hs3_first, 660);
    check("de0_vs_valid",   de0_mis,   0);
    check("de1_fall",       de1_fall,  642);
    check("de3_rise",       de3_rise,  4);
    check("de3_fall",       de3_fall,  644);

    tick();
    check("line1_x",     32'(x1),  0);
    check("line1_y",     32'(y1),  1);
    check("line1_valid", 32'(v1),  1);
    check("line1_fs",    32'(fs1), 0);

    // EN toggling 1010... over one line of enabled cycles.
    hold_err = 0; adv_err = 0; en_val_clk = 0; en_hs_clk = 0;
    for (int i = 0; i < 1600; i++) begin
      en  = (i % 2 == 0);
      px  = x1;
      pv  = v1;
      phs = hs1;
      tick();
      if (!en && (x1 != px || v1 != pv || hs1 != phs)) hold_err++;
      if (en && v1 && pv && int'(x1) != int'(px) + 1) adv_err++;
      if (v1) en_val_clk++;
      if (!hs1) en_hs_clk++;
    end
    en = 1'b1;
    check("en_hold",      hold_err,   0);
    check("en_advance",   adv_err,    0);
    check("en_valid_clk", en_val_clk, 1280);
    check("en_hs_clk",    en_hs_clk,  192);
    check("en_end_x",     32'(x1),    0);
    check("en_end_y",     32'(y1),    2);
    check("en_end_valid", 32'(v1),    1);

    // Asynchronous reset in the middle of an active line.
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      tick();
      if (int'(x1) == 300) found = 1;
    end
    check("reach_x300", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_x",     32'(x1),  0);
    check("mr_y",     32'(y1),  0);
    check("mr_valid", 32'(v1),  0);
    check("mr_de",    32'(de1), 0);
    check("mr_de3",   32'(de3), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("mr_first_x",     32'(x1),  0);
    check("mr_first_y",     32'(y1),  0);
    check("mr_first_valid", 32'(v1),  1);
    check("mr_first_fs",    32'(fs1), 1);

    // Asynchronous reset while the whole delay line holds an asserted HSYNC.
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      tick();
      if (!hs3) found = 1;
    end
    check("reach_hsync", found, 1);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("sr_hs3", 32'(hs3), 1);
    check("sr_hs1", 32'(hs1), 1);
    check("sr_hs0", 32'(hs0), 1);
    @(negedge clk) rst_n = 1'b1;
    stale = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (!hs3 || !hs1 || !hs0) stale++;
    end
    check("no_stale_sync", stale, 0);

    // Two-plus frames on the small raster (160 enabled cycles per frame).
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    fs_cnt = 0; fs_first = 0; fs_second = 0; vs_cnt = 0; vs_first = 0;
    ymax = 0; xmax = 0; de_mis = 0; hs_s_cnt = 0; hs_s_first = 0;
    pvals = 1'b0;
    for (int k = 1; k <= 340; k++) begin
      tick();
      if (fss) begin
        fs_cnt++;
        if (fs_first == 0) fs_first = k;
        else if (fs_second == 0) fs_second = k;
      end
      if (k <= 160 && !vss) begin
        vs_cnt++;
        if (vs_first == 0) vs_first = k;
      end
      if (vals && int'(ys) > ymax) ymax = int'(ys);
      if (vals && int'(xs) > xmax) xmax = int'(xs);
      if (k >= 2 && des != pvals) de_mis++;
      pvals = vals;
      if (k <= 16 && hss) begin
        hs_s_cnt++;
        if (hs_s_first == 0) hs_s_first = k;
      end
    end
    check("s_fs_first",  fs_first,   1);
    check("s_fs_period", fs_second,  161);
    check("s_fs_count",  fs_cnt,     3);
    check("s_vs_width",  vs_cnt,     32);
    check("s_vs_first",  vs_first,   114);
    check("s_ymax",      ymax,       5);
    check("s_xmax",      xmax,       7);
    check("s_de_delay",  de_mis,     0);
    check("s_hs_width",  hs_s_cnt,   3);
    check("s_hs_first",  hs_s_first, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Raster timing generator that sits directly upstream of the pixel colour stage. It produces pixel coordinates X/Y, the active-area flag valid, and the HSYNC/VSYNC pulses. Sync outputs and a delayed data-enable are pipelined by PIPE_DLY cycles so they line up with the registered colour decode in the downstream stage. Defaults give 640x480@60 Hz from a 25.175 MHz VGA_CLK.

Parameters:
P_WIDTH, 11, width of X/Y and of the internal counters; H_TOTAL and V_TOTAL must each be <= 2^P_WIDTH
H_ACT, 640, active pixels per line
H_FP, 16, horizontal front porch, in pixels
H_SYNC, 96, horizontal sync width, in pixels
H_BP, 48, horizontal back porch, in pixels
V_ACT, 480, active lines per frame
V_FP, 10, vertical front porch, in lines
V_SYNC, 2, vertical sync width, in lines
V_BP, 33, vertical back porch, in lines
HS_POL, 0, HSYNC asserted level (0 = active-low)
VS_POL, 0, VSYNC asserted level
PIPE_DLY, 1, delay in enabled cycles on HSYNC/VSYNC/DE relative to X/Y/valid; 0..7

Ports:
VGA_CLK  in  1  pixel clock; all logic on the rising edge
RST_N  in  1  asynchronous active-low reset
EN  in  1  pixel enable; when 0, all state freezes
X  out  P_WIDTH  horizontal pixel coordinate
Y  out  P_WIDTH  vertical line coordinate
valid  out  1  1 when (X,Y) lies inside the active area
FRAME_START  out  1  one-cycle pulse together with pixel (0,0)
HSYNC  out  1  horizontal sync, delayed by PIPE_DLY
VSYNC  out  1  vertical sync, delayed by PIPE_DLY
DE  out  1  valid delayed by PIPE_DLY

Behaviour:
- Derived totals: H_TOTAL = H_ACT+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACT+V_FP+V_SYNC+V_BP (525).
- Counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1) advance only on edges where EN=1.
  - h_cnt wraps to 0 after H_TOTAL-1.
  - v_cnt increments only when h_cnt wraps, and wraps to 0 after V_TOTAL-1.
- Region order on each line: active [0,H_ACT), front porch, sync [H_ACT+H_FP, H_ACT+H_FP+H_SYNC), back porch. The same order applies vertically, counted in lines.
- All outputs are registered decodes of the counter state. On each enabled edge:
  - valid <= (h_cnt<H_ACT && v_cnt<V_ACT)
  - X <= valid-term ? h_cnt : 0; Y <= valid-term ? v_cnt : 0
  - FRAME_START <= (h_cnt==0 && v_cnt==0)
  - undelayed hs/vs are HS_POL/VS_POL inside their sync windows and the inverse outside.
- VSYNC window is line-based: it is asserted for every pixel of lines V_ACT+V_FP .. V_ACT+V_FP+V_SYNC-1 (490..491).
- Delay line: PIPE_DLY-stage shift register for {hs, vs, valid}, advancing only when EN=1.
  - HSYNC/VSYNC/DE take the last stage.
  - PIPE_DLY=0 connects them directly to the undelayed registered values.
- EN=0: counters, output registers and the delay line all hold. FRAME_START holds its value, so a bench counts pulses only on EN=1 cycles.
- Reset (asynchronous, mid-frame included):
  - h_cnt=v_cnt=0; X=0, Y=0, valid=0, FRAME_START=0, DE=0
  - HSYNC=~HS_POL, VSYNC=~VS_POL, and every delay stage loaded with these deasserted levels.
- Exit from reset: the first enabled edge after RST_N rises presents pixel (0,0): valid=1, FRAME_START=1, X=0, Y=0.
- Frame period: exactly H_TOTAL*V_TOTAL enabled cycles between FRAME_START pulses (420000 at defaults).
- No arithmetic overflow: counter compares are done at P_WIDTH bits, and the parameter legality rule above is a design-time requirement.

Test Plan:
- Reset/first pixel: hold RST_N=0 with EN=1 -> X=0, Y=0, valid=0, DE=0, HSYNC=VSYNC=1. Release; first edge -> valid=1, FRAME_START=1, (0,0). Second edge -> X=1, FRAME_START=0.
- Line timing: run one line -> valid high for 640 cycles, X counts 0..639. X=0 and valid=0 for 160 cycles. Undelayed hs low for 96 cycles starting at h_cnt=656. HSYNC follows exactly 1 cycle later at PIPE_DLY=1.
- Frame timing: run 2 frames -> FRAME_START pulses exactly 420000 cycles apart. VSYNC low for 1600 cycles (lines 490-491). Y reaches 479 max while valid. DE is valid delayed by 1.
- EN gating: toggle EN 1010... for one line -> X advances only on EN=1 edges. The line takes 1600 clocks, and the HSYNC width is 192 clocks.
- Mid-frame reset: assert RST_N=0 asynchronously at (X=300, Y=200) between clock edges -> outputs reach reset values immediately. After release, (0,0) appears on the first edge. The delay line contains no stale sync.
- PIPE_DLY=0 and PIPE_DLY=3 builds: HSYNC/DE edges lag the valid/hs decode by exactly 0 and 3 enabled cycles.
